// File: rtl/kanagawa_hal_multi_channel_fifo.sv
// Bank of NUM_CHANNELS show-ahead FIFOs sharing one storage array, one push and one pop port.
// Per-channel pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
module kanagawa_hal_multi_channel_fifo #(
    parameter int NUM_CHANNELS               = 4,
    parameter int DEPTH                      = 24,
    parameter int LOG_DEPTH                  = $clog2(DEPTH),
    parameter int CHAN_WIDTH                 = (NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1),
    parameter int WIDTH                      = 32,
    parameter int USEDW_WIDTH                = LOG_DEPTH + 1,
    parameter int ALMOSTFULL_ENTRIES         = 1,
    parameter int OVER_UNDER_FLOW_PROTECTION = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wrreq,
    input  logic [CHAN_WIDTH-1:0]               wrchan,
    input  logic [WIDTH-1:0]                    data,
    input  logic                                rdreq,
    input  logic [CHAN_WIDTH-1:0]               rdchan,
    output logic [WIDTH-1:0]                    q,
    output logic [NUM_CHANNELS-1:0]             full,
    output logic [NUM_CHANNELS-1:0]             almost_full,
    output logic [NUM_CHANNELS-1:0]             empty,
    output logic [NUM_CHANNELS*USEDW_WIDTH-1:0] usedw,
    output logic [NUM_CHANNELS-1:0]             overflow,
    output logic [NUM_CHANNELS-1:0]             underflow,
    output logic                                chan_error
);
    localparam int AW     = $clog2(NUM_CHANNELS * DEPTH);
    localparam int AF_TH  = DEPTH - ALMOSTFULL_ENTRIES;
    localparam bit AF_RST = (0 >= AF_TH);
    localparam bit PROT   = (OVER_UNDER_FLOW_PROTECTION != 0);

    if (LOG_DEPTH != $clog2(DEPTH)) begin : g_chk_log_depth
        $error("LOG_DEPTH must equal $clog2(DEPTH)");
    end
    if (USEDW_WIDTH != LOG_DEPTH + 1) begin : g_chk_usedw
        $error("USEDW_WIDTH must equal LOG_DEPTH+1");
    end

    logic [WIDTH-1:0] mem [NUM_CHANNELS*DEPTH];

    logic [NUM_CHANNELS-1:0][LOG_DEPTH-1:0]   wrptr, rdptr;
    logic [NUM_CHANNELS-1:0][USEDW_WIDTH-1:0] used, used_nxt;
    logic [NUM_CHANNELS-1:0]                  push_c, pop_c, wr_hit, rd_hit;
    logic                                     wr_ok, rd_ok, push, pop;
    logic [CHAN_WIDTH-1:0]                    wr_sel, rd_sel;
    logic [AW-1:0]                            wr_addr, rd_addr;

    // Only a non-power-of-two channel count can see an out-of-range index.
    if (NUM_CHANNELS == 2**CHAN_WIDTH) begin : g_all_valid
        assign wr_ok = 1'b1;
        assign rd_ok = 1'b1;
    end else begin : g_range_chk
        assign wr_ok = (wrchan < CHAN_WIDTH'(NUM_CHANNELS));
        assign rd_ok = (rdchan < CHAN_WIDTH'(NUM_CHANNELS));
    end

    assign wr_sel  = wr_ok ? wrchan : '0;
    assign rd_sel  = rd_ok ? rdchan : '0;
    assign push    = wrreq & wr_ok & (~PROT | ~full[wr_sel]);
    assign pop     = rdreq & rd_ok & (~PROT | ~empty[rd_sel]);
    assign wr_addr = AW'(wr_sel) * AW'(DEPTH) + AW'(wrptr[wr_sel]);
    assign rd_addr = AW'(rd_sel) * AW'(DEPTH) + AW'(rdptr[rd_sel]);
    assign q       = mem[rd_addr];
    assign usedw   = used;

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            wr_hit[c]   = wrreq & wr_ok & (wr_sel == CHAN_WIDTH'(c));
            rd_hit[c]   = rdreq & rd_ok & (rd_sel == CHAN_WIDTH'(c));
            push_c[c]   = push & (wr_sel == CHAN_WIDTH'(c));
            pop_c[c]    = pop & (rd_sel == CHAN_WIDTH'(c));
            used_nxt[c] = used[c] + USEDW_WIDTH'(push_c[c]) - USEDW_WIDTH'(pop_c[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_addr] <= data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr       <= '0;
            rdptr       <= '0;
            used        <= '0;
            empty       <= '1;
            full        <= '0;
            almost_full <= {NUM_CHANNELS{AF_RST}};
            overflow    <= '0;
            underflow   <= '0;
            chan_error  <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (push_c[c])
                    wrptr[c] <= (wrptr[c] == LOG_DEPTH'(DEPTH-1)) ? '0 : wrptr[c] + 1'b1;
                if (pop_c[c])
                    rdptr[c] <= (rdptr[c] == LOG_DEPTH'(DEPTH-1)) ? '0 : rdptr[c] + 1'b1;
                used[c]        <= used_nxt[c];
                full[c]        <= (used_nxt[c] == USEDW_WIDTH'(DEPTH));
                empty[c]       <= (used_nxt[c] == '0);
                almost_full[c] <= (int'(used_nxt[c]) >= AF_TH);
                // Error flags judge the request against the flags visible this cycle.
                overflow[c]    <= overflow[c] | (wr_hit[c] & full[c]);
                underflow[c]   <= underflow[c] | (rd_hit[c] & empty[c]);
            end
            chan_error <= chan_error | (wrreq & ~wr_ok) | (rdreq & ~rd_ok);
        end
    end
endmodule

// File: tb/tb_kanagawa_hal_multi_channel_fifo.sv
// Directed + random bench for the multi-channel FIFO, checked against per-channel queue model.
module tb_kanagawa_hal_multi_channel_fifo;
    localparam int NC = 3;
    localparam int D  = 24;
    localparam int UW = 6;
    localparam int W  = 32;

    logic              clk = 1'b0;
    logic              rst, wrreq, rdreq;
    logic [1:0]        wrchan, rdchan;
    logic [W-1:0]      data, q;
    logic [NC-1:0]     full, almost_full, empty, overflow, underflow;
    logic [NC*UW-1:0]  usedw;
    logic              chan_error;

    kanagawa_hal_multi_channel_fifo #(
        .NUM_CHANNELS(NC), .DEPTH(D), .WIDTH(W),
        .ALMOSTFULL_ENTRIES(1), .OVER_UNDER_FLOW_PROTECTION(1)
    ) dut (
        .clk(clk), .rst(rst), .wrreq(wrreq), .wrchan(wrchan), .data(data),
        .rdreq(rdreq), .rdchan(rdchan), .q(q), .full(full), .almost_full(almost_full),
        .empty(empty), .usedw(usedw), .overflow(overflow), .underflow(underflow),
        .chan_error(chan_error)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mq [NC][$];
    bit   [NC-1:0] m_ovf, m_unf;
    bit            m_cerr;
    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        logic [NC*UW-1:0] eu;
        logic [NC-1:0]    ee, ef, eaf;
        for (int c = 0; c < NC; c++) begin
            eu[c*UW +: UW] = UW'(mq[c].size());
            ee[c]  = (mq[c].size() == 0);
            ef[c]  = (mq[c].size() == D);
            eaf[c] = (mq[c].size() >= D - 1);
        end
        chk("usedw", 64'(usedw), 64'(eu));
        chk("empty", 64'(empty), 64'(ee));
        chk("full", 64'(full), 64'(ef));
        chk("almost_full", 64'(almost_full), 64'(eaf));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_unf));
        chk("chan_error", 64'(chan_error), 64'(m_cerr));
    endtask

    // One clock: drive, check show-ahead head, advance model, check registered state.
    task automatic cyc(input bit r, input bit wq, input int wc, input logic [W-1:0] d,
                       input bit rq, input int rc);
        bit wv, rv, fw, er;
        rst = r; wrreq = wq; wrchan = wc[1:0]; data = d; rdreq = rq; rdchan = rc[1:0];
        #1;
        if (!r && rc < NC && mq[rc].size() > 0) chk("q", 64'(q), 64'(mq[rc][0]));
        if (r) begin
            for (int c = 0; c < NC; c++) mq[c].delete();
            m_ovf = '0; m_unf = '0; m_cerr = 1'b0;
        end else begin
            wv = (wc < NC); rv = (rc < NC);
            if ((wq && !wv) || (rq && !rv)) m_cerr = 1'b1;
            fw = wv && (mq[wv ? wc : 0].size() == D);
            er = rv && (mq[rv ? rc : 0].size() == 0);
            if (wq && fw) m_ovf[wc] = 1'b1;
            if (rq && er) m_unf[rc] = 1'b1;
            if (rq && rv && !er) void'(mq[rc].pop_front());
            if (wq && wv && !fw) mq[wc].push_back(d);
        end
        @(posedge clk); #1;
        check_state();
    endtask

    initial begin
        rst = 1'b1; wrreq = 1'b0; rdreq = 1'b0; wrchan = '0; rdchan = '0; data = '0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'h55, 0, 0);

        // Fill channel 2, overflow it, drain it in order.
        for (int i = 0; i < D; i++) cyc(0, 1, 2, i, 0, 2);
        cyc(0, 1, 2, 99, 0, 2);
        for (int i = 0; i < D; i++) cyc(0, 0, 0, 0, 1, 2);

        // Pointer wrap on channel 2 with interleaved push/pop.
        for (int i = 0; i < 30; i++) begin
            cyc(0, 1, 2, 32'h100 + i, 0, 2);
            cyc(0, 0, 0, 0, 1, 2);
        end

        // Interleave channels 0 and 1, read back ch1 then ch0.
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 32'hA00 + i, 0, 0);
            cyc(0, 1, 1, 32'hB00 + i, 0, 1);
        end
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 0);

        // Simultaneous push+pop at used=5, then at empty.
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'hC00 + i, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'hC10 + i, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 32'hC20, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Invalid channel on both ports.
        cyc(0, 1, 3, 32'hDEAD, 0, 0);
        cyc(0, 0, 0, 0, 1, 3);

        // Reset discards contents and sticky flags; push during reset is dropped.
        for (int i = 0; i < D; i++) cyc(0, 1, 0, 32'hE00 + i, 0, 0);
        cyc(0, 1, 0, 32'hEFF, 0, 0);
        for (int i = 0; i < D - 10; i++) cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 32'hBEEF, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Random traffic, biased to fill then drain.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                int wc, rc;
                bit wq, rq, r;
                wc = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, NC - 1));
                rc = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, NC - 1));
                wq = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 8 : 3));
                rq = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 3 : 8));
                r  = ($urandom_range(0, 199) == 0);
                cyc(r, wq, wc, $urandom, rq, rc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
